gate_truth_checker: RTL
=======================

GATE_TRUTH_CHECKER -- requirements
Module: gate_truth_checker

Interface
REQ-001 SHALL have parameter OP, default 0, giving the expected gate function: 0 OR, 1 AND, 2 NOR, 3 NAND, 4 XOR, 5 XNOR; 6 and 7 mean expected Z=0.
REQ-002 SHALL have parameter SETTLE, default 2, giving cycles per vector (range 1..15); a value of 0 SHALL behave as 1.
REQ-003 SHALL have port CLK, input, 1, the only clock; all state updates on its rising edge.
REQ-004 SHALL have port RSTN, input, 1; reset is synchronous and active-low.
REQ-005 SHALL have port START, input, 1, run request, sampled in IDLE only.
REQ-006 SHALL have port Z, input, 1, output of the gate under test.
REQ-007 SHALL have port A, output, 1, stimulus operand A to the gate under test.
REQ-008 SHALL have port B, output, 1, stimulus operand B to the gate under test.
REQ-009 SHALL have port BUSY, output, 1, high while vectors are applied.
REQ-010 SHALL have port DONE, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port PASS, output, 1, set when the last run had no mismatch; held until the next run completes.
REQ-012 SHALL have port FAIL_MASK, output, 4; bit i set when vector i ({A,B}=i) mismatched in the last run.
REQ-013 SHALL have port RUNS, output, 8, count of completed runs.

Function
REQ-014 SHALL implement a FSM with states IDLE, APPLY and REPORT.
REQ-015 In IDLE with START=1 at edge k, SHALL enter APPLY, set BUSY=1, set vector index=0 and {A,B}=00.
REQ-016 In APPLY, SHALL hold each vector for SETTLE cycles; Z for vector i SHALL be sampled at edge k+(i+1)*SETTLE.
REQ-017 At each sample edge, SHALL compare Z with the expected function of the current A,B and record any mismatch in a working mask bit i.
REQ-018 At a sample edge for i<3, SHALL advance to vector i+1 and drive {A,B}=i+1 from that edge.
REQ-019 At the sample edge for i=3 (edge k+4*SETTLE), SHALL do all of the following together:
- enter REPORT, BUSY=0, DONE=1
- FAIL_MASK=working mask, PASS=(mask==0), RUNS=RUNS+1
- {A,B}=00.
REQ-020 REPORT SHALL last exactly one cycle, then go to IDLE with DONE=0.
REQ-021 The total run SHALL be 4*SETTLE cycles BUSY plus 1 cycle DONE; a new START SHALL be accepted no earlier than the IDLE cycle after REPORT.
REQ-022 START SHALL be ignored in APPLY and REPORT; START held high SHALL restart a run on each IDLE cycle.
REQ-023 The working mask SHALL clear on START acceptance; PASS, FAIL_MASK and RUNS SHALL NOT change during APPLY.
REQ-024 RUNS SHALL wrap from 255 to 0 with no flag.
REQ-025 In IDLE, A and B SHALL be 0.

Reset
REQ-026 With RSTN=0 at an edge, SHALL force state=IDLE, A=B=BUSY=DONE=PASS=0, FAIL_MASK=0000, RUNS=0, index and working mask=0.
REQ-027 Reset SHALL take priority over START and SHALL abort any run in progress with no DONE pulse.

Verification
REQ-028 SHALL pass this scenario: OP=0, SETTLE=2, Z=A|B, 1-cycle START -> A,B step 00,01,10,11 every 2 cycles; BUSY 8 cycles; DONE pulse in cycle 9; PASS=1, FAIL_MASK=0000, RUNS=1.
REQ-029 SHALL pass this scenario: OP=0, Z tied 0 -> FAIL_MASK=1110, PASS=0.
REQ-030 SHALL pass this scenario: OP=4 (XOR), Z=A|B -> FAIL_MASK=1000, PASS=0; then OP=2 with a NOR model -> PASS=1.
REQ-031 SHALL pass this scenario: START held high for 3 runs -> RUNS 1,2,3; exactly one REPORT cycle and one IDLE cycle between BUSY periods; START pulses while BUSY=1 have no effect.
REQ-032 SHALL pass this scenario: RSTN=0 during the 3rd APPLY cycle -> at the next edge all outputs are 0 and no DONE pulse occurs; a following START completes a clean run with RUNS=1.
REQ-033 SHALL pass this scenario: 256 completed runs -> RUNS wraps to 0 with PASS still valid.

Source files
------------

// File: rtl/gate_truth_checker.sv
// -----------------------------------------------------------------------------
// gate_truth_checker
//
// Purpose:
//   Exercises a two-input gate under test with all four input vectors
//   ({A,B} = 00, 01, 10, 11). Each vector is held for SETTLE clock cycles.
//   The gate output Z is sampled on the last edge of each vector and compared
//   with the expected gate function selected by OP. At the end of a run the
//   per-vector mismatch mask is published, PASS is updated, the run counter
//   increments, and DONE pulses for one cycle.
//
// Parameters:
//   OP     : expected gate: 0 OR, 1 AND, 2 NOR, 3 NAND, 4 XOR, 5 XNOR,
//            6/7 expect Z = 0
//   SETTLE : cycles per vector, 1..15 (0 behaves as 1)
//
// Ports:
//   CLK       in   clock, all state changes on the rising edge
//   RSTN      in   synchronous active-low reset
//   START     in   run request, only looked at in IDLE
//   Z         in   output of the gate under test
//   A, B      out  stimulus operands to the gate under test
//   BUSY      out  high while vectors are being applied
//   DONE      out  one-cycle completion pulse
//   PASS      out  last completed run had no mismatch
//   FAIL_MASK out  bit i set when vector i mismatched in the last run
//   RUNS      out  completed-run counter, wraps 255 -> 0
// -----------------------------------------------------------------------------
//   state  | meaning
//   IDLE   | A=B=0, waiting for START
//   APPLY  | driving vector r_idx, counting down the settle time
//   REPORT | one-cycle DONE pulse, results already published
// -----------------------------------------------------------------------------
module gate_truth_checker #(
  parameter int unsigned OP     = 0,
  parameter int unsigned SETTLE = 2
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       START,
  input  logic       Z,
  output logic       A,
  output logic       B,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] FAIL_MASK,
  output logic [7:0] RUNS
);

  // Effective settle length, with 0 folded onto 1. The counter is loaded with
  // SETTLE-1 and the vector is sampled when it reaches zero.
  localparam int unsigned  SETTLE_EFF = (SETTLE == 0) ? 1 : SETTLE;
  localparam logic [3:0]   SETTLE_M1  = 4'(SETTLE_EFF - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t     r_state;
  logic [1:0] r_idx;
  logic [3:0] r_cnt;
  logic [3:0] r_mask;
  logic       r_a;
  logic       r_b;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_fail_mask;
  logic [7:0] r_runs;

  state_t     w_state_nxt;
  logic [1:0] w_idx_nxt;
  logic [3:0] w_cnt_nxt;
  logic [3:0] w_mask_nxt;
  logic       w_a_nxt;
  logic       w_b_nxt;
  logic       w_busy_nxt;
  logic       w_done_nxt;
  logic       w_pass_nxt;
  logic [3:0] w_fail_mask_nxt;
  logic [7:0] w_runs_nxt;

  logic       w_expected;
  logic       w_mismatch;
  logic [3:0] w_mask_upd;
  logic [1:0] w_idx_inc;

  // Expected gate output for the vector currently on A,B.
  always_comb begin
    w_expected = 1'b0;
    case (OP)
      0:       w_expected =   r_a | r_b;
      1:       w_expected =   r_a & r_b;
      2:       w_expected = ~(r_a | r_b);
      3:       w_expected = ~(r_a & r_b);
      4:       w_expected =   r_a ^ r_b;
      5:       w_expected = ~(r_a ^ r_b);
      default: w_expected = 1'b0;
    endcase
  end

  assign w_mismatch = (Z != w_expected);
  assign w_mask_upd = r_mask | ({3'b000, w_mismatch} << r_idx);
  assign w_idx_inc  = r_idx + 2'd1;

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_cnt_nxt       = r_cnt;
    w_mask_nxt      = r_mask;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_pass_nxt      = r_pass;
    w_fail_mask_nxt = r_fail_mask;
    w_runs_nxt      = r_runs;

    case (r_state)
      IDLE: begin
        w_a_nxt    = 1'b0;
        w_b_nxt    = 1'b0;
        w_busy_nxt = 1'b0;
        if (START) begin
          w_state_nxt = APPLY;
          w_busy_nxt  = 1'b1;
          w_idx_nxt   = 2'd0;
          w_cnt_nxt   = SETTLE_M1;
          w_mask_nxt  = 4'b0000;
        end
      end

      APPLY: begin
        if (r_cnt == 4'd0) begin
          // Sample edge for vector r_idx.
          w_mask_nxt = w_mask_upd;
          if (r_idx == 2'd3) begin
            w_state_nxt     = REPORT;
            w_busy_nxt      = 1'b0;
            w_done_nxt      = 1'b1;
            w_fail_mask_nxt = w_mask_upd;
            w_pass_nxt      = (w_mask_upd == 4'b0000);
            w_runs_nxt      = r_runs + 8'd1;
            w_a_nxt         = 1'b0;
            w_b_nxt         = 1'b0;
          end else begin
            w_idx_nxt          = w_idx_inc;
            {w_a_nxt, w_b_nxt} = w_idx_inc;
            w_cnt_nxt          = SETTLE_M1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end

      REPORT: begin
        // START is deliberately not looked at here; the earliest restart is
        // the IDLE cycle that follows.
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
        w_a_nxt     = 1'b0;
        w_b_nxt     = 1'b0;
      end

      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
        w_a_nxt     = 1'b0;
        w_b_nxt     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_state     <= IDLE;
      r_idx       <= 2'd0;
      r_cnt       <= 4'd0;
      r_mask      <= 4'b0000;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_mask <= 4'b0000;
      r_runs      <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mask      <= w_mask_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_pass      <= w_pass_nxt;
      r_fail_mask <= w_fail_mask_nxt;
      r_runs      <= w_runs_nxt;
    end
  end

  assign A         = r_a;
  assign B         = r_b;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign PASS      = r_pass;
  assign FAIL_MASK = r_fail_mask;
  assign RUNS      = r_runs;

endmodule
